monitor_uart_arbiter: RTL and testbench

- Synchronous controller for the monitor's UART-over-SPI bridge, clocked by MCLK_IN.
- Shares the single UART send channel between two requesters, the 68000 bus-side port (CPU) and the debug/boot port (DBG), using round-robin arbitration.
- Generates the edge-triggered send and capture strobes the monitor consumes.
- Drains received bytes into a small RX FIFO. When the FIFO is full, capture is withheld, so the SPI host sees the receive side as busy and no byte is lost.

---
 rtl/monitor_uart_arbiter_if.sv | 52 +++++
 rtl/monitor_uart_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_monitor_uart_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_uart_arbiter_if.sv
// Purpose: handshake/data bundle between the monitor UART arbiter and its requesters and monitor.
// Latency: none (wiring only).
// Backpressure: carries per-requester READY pulses and the RX FIFO pop/valid pair.
// Ports: CPU_TX_*/DBG_TX_* requester channels, UART_* monitor side, RX_* FIFO drain side,
//        LOOPBACK_IN only when MONITOR_UART_LOOPBACK_EN is defined.
// Modports: slave = arbiter, master = requesters/monitor/consumer.
interface monitor_uart_arbiter_if #(
  parameter int RX_DEPTH = 4
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic          CPU_TX_VALID_IN;
  logic [7:0]    CPU_TX_BYTE_IN;
  logic          CPU_TX_READY;
  logic          DBG_TX_VALID_IN;
  logic [7:0]    DBG_TX_BYTE_IN;
  logic          DBG_TX_READY;
  logic          UART_SEND_BUSY_IN;
  logic          UART_RECEIVED_IN;
  logic [7:0]    UART_RECEIVE_BYTE_IN;
  logic          UART_SEND_TRIGGER;
  logic [7:0]    UART_SEND_BYTE;
  logic          UART_RECEIVE_CAPTURE;
  logic          RX_POP_IN;
  logic [7:0]    RX_BYTE;
  logic          RX_VALID;
  logic [CW-1:0] RX_COUNT;
  logic          TX_IDLE;
`ifdef MONITOR_UART_LOOPBACK_EN
  logic          LOOPBACK_IN;
`endif

  modport slave (
`ifdef MONITOR_UART_LOOPBACK_EN
    input  LOOPBACK_IN,
`endif
    input  CPU_TX_VALID_IN, CPU_TX_BYTE_IN, DBG_TX_VALID_IN, DBG_TX_BYTE_IN,
    input  UART_SEND_BUSY_IN, UART_RECEIVED_IN, UART_RECEIVE_BYTE_IN, RX_POP_IN,
    output CPU_TX_READY, DBG_TX_READY, UART_SEND_TRIGGER, UART_SEND_BYTE,
    output UART_RECEIVE_CAPTURE, RX_BYTE, RX_VALID, RX_COUNT, TX_IDLE
  );

  modport master (
`ifdef MONITOR_UART_LOOPBACK_EN
    output LOOPBACK_IN,
`endif
    output CPU_TX_VALID_IN, CPU_TX_BYTE_IN, DBG_TX_VALID_IN, DBG_TX_BYTE_IN,
    output UART_SEND_BUSY_IN, UART_RECEIVED_IN, UART_RECEIVE_BYTE_IN, RX_POP_IN,
    input  CPU_TX_READY, DBG_TX_READY, UART_SEND_TRIGGER, UART_SEND_BYTE,
    input  UART_RECEIVE_CAPTURE, RX_BYTE, RX_VALID, RX_COUNT, TX_IDLE
  );
endinterface

// File: rtl/monitor_uart_arbiter.sv
// Purpose: round-robin CPU/DBG arbiter for the monitor UART send channel plus RX capture into a FIFO.
// Latency: READY 1 cycle after VALID seen idle; trigger 1 cycle after READY; RX write visible next cycle.
// Backpressure: one grant per send handshake; capture withheld while the RX FIFO is full.
// Ports: MCLK_IN clock, RUN_IN synchronous active-low reset, bus = monitor_uart_arbiter_if.slave.
// Optional: MONITOR_UART_LOOPBACK_EN adds LOOPBACK_IN, routing granted bytes straight into the RX FIFO.
module monitor_uart_arbiter #(
  parameter int RX_DEPTH     = 4,
  parameter int TRIG_CYCLES  = 2,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic                   MCLK_IN,
  input logic                   RUN_IN,
  monitor_uart_arbiter_if.slave bus
);
  localparam int AW   = $clog2(RX_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (TRIG_CYCLES > BUSY_TIMEOUT) ? TRIG_CYCLES : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(TRIG_CYCLES + 1);

  typedef enum logic [2:0] {T_IDLE, T_SETUP, T_TRIG, T_WAITHI, T_WAITLO} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CAPT, R_WAIT} rx_state_t;

  tx_state_t     t_state;
  rx_state_t     r_state;
  logic          busy_s1, busy_s2, rcv_s1, rcv_s2;
  logic          cpu_rdy, dbg_rdy, trig, capt, tx_idle;
  logic          last_dbg;   // 1 when DBG held the previous grant
  logic          lb_pend;    // current grant was a loopback push
  logic [7:0]    send_byte;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;

  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          lb;
`ifdef MONITOR_UART_LOOPBACK_EN
  assign lb = bus.LOOPBACK_IN;
`else
  assign lb = 1'b0;
`endif

  // Grant and FIFO push decisions shared by both FSMs and the FIFO.
  logic       full, pick_cpu, grant, lb_push, rx_push, push, pop;
  logic [7:0] win_byte, push_dat;
  always_comb begin
    full     = (count == CW'(RX_DEPTH));
    // CPU wins when alone, or on a tie when DBG was granted last.
    pick_cpu = bus.CPU_TX_VALID_IN & (~bus.DBG_TX_VALID_IN | last_dbg);
    win_byte = pick_cpu ? bus.CPU_TX_BYTE_IN : bus.DBG_TX_BYTE_IN;
    // In loopback the grant stalls on a full FIFO since the byte lands there directly.
    grant    = (t_state == T_IDLE) & (bus.CPU_TX_VALID_IN | bus.DBG_TX_VALID_IN) & ~(lb & full);
    lb_push  = grant & lb;
    rx_push  = (r_state == R_IDLE) & rcv_s2 & ~full & ~lb;
    push     = lb_push | rx_push;
    push_dat = lb_push ? win_byte : bus.UART_RECEIVE_BYTE_IN;
    pop      = bus.RX_POP_IN & (count != '0);
  end

  always_ff @(posedge MCLK_IN) begin
    if (!RUN_IN) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      rcv_s1  <= 1'b0;
      rcv_s2  <= 1'b0;
    end else begin
      busy_s1 <= bus.UART_SEND_BUSY_IN;
      busy_s2 <= busy_s1;
      rcv_s1  <= bus.UART_RECEIVED_IN;
      rcv_s2  <= rcv_s1;
    end
  end

  // TX FSM
  always_ff @(posedge MCLK_IN) begin
    if (!RUN_IN) begin
      t_state   <= T_IDLE;
      cpu_rdy   <= 1'b0;
      dbg_rdy   <= 1'b0;
      trig      <= 1'b0;
      tx_idle   <= 1'b1;
      last_dbg  <= 1'b1;
      lb_pend   <= 1'b0;
      send_byte <= 8'h00;
      tcnt      <= '0;
    end else begin
      cpu_rdy <= 1'b0;
      dbg_rdy <= 1'b0;
      case (t_state)
        T_IDLE: begin
          if (grant) begin
            cpu_rdy   <= pick_cpu;
            dbg_rdy   <= ~pick_cpu;
            last_dbg  <= ~pick_cpu;
            send_byte <= win_byte;
            lb_pend   <= lb;
            tx_idle   <= 1'b0;
            t_state   <= T_SETUP;
          end
        end
        T_SETUP: begin
          if (lb_pend) begin
            lb_pend <= 1'b0;
            tx_idle <= 1'b1;
            t_state <= T_IDLE;
          end else begin
            trig    <= 1'b1;
            tcnt    <= '0;
            t_state <= T_TRIG;
          end
        end
        T_TRIG: begin
          if (tcnt == TW'(TRIG_CYCLES - 1)) begin
            trig    <= 1'b0;
            tcnt    <= '0;
            t_state <= T_WAITHI;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        T_WAITHI: begin
          // A short send can finish before busy is ever seen; the timeout treats that as done.
          if (busy_s2) begin
            t_state <= T_WAITLO;
          end else if (tcnt == TW'(BUSY_TIMEOUT - 1)) begin
            tx_idle <= 1'b1;
            t_state <= T_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        T_WAITLO: begin
          if (!busy_s2) begin
            tx_idle <= 1'b1;
            t_state <= T_IDLE;
          end
        end
        default: begin
          trig    <= 1'b0;
          tx_idle <= 1'b1;
          t_state <= T_IDLE;
        end
      endcase
    end
  end

  // RX FSM
  always_ff @(posedge MCLK_IN) begin
    if (!RUN_IN) begin
      r_state <= R_IDLE;
      capt    <= 1'b0;
      rcnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (rx_push) begin
            capt    <= 1'b1;
            rcnt    <= '0;
            r_state <= R_CAPT;
          end
        end
        R_CAPT: begin
          if (rcnt == RW'(TRIG_CYCLES - 1)) begin
            capt    <= 1'b0;
            r_state <= R_WAIT;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        R_WAIT: begin
          // Wait for the monitor to retract its flag so the same byte is not taken twice.
          if (!rcv_s2) r_state <= R_IDLE;
        end
        default: begin
          capt    <= 1'b0;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // RX FIFO
  always_ff @(posedge MCLK_IN) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge MCLK_IN) begin
    if (!RUN_IN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.CPU_TX_READY         = cpu_rdy;
  assign bus.DBG_TX_READY         = dbg_rdy;
  assign bus.UART_SEND_TRIGGER    = trig;
  assign bus.UART_SEND_BYTE       = send_byte;
  assign bus.UART_RECEIVE_CAPTURE = capt;
  assign bus.TX_IDLE              = tx_idle;
  assign bus.RX_BYTE              = mem[rd_ptr];
  assign bus.RX_VALID             = (count != '0);
  assign bus.RX_COUNT             = count;
endmodule

// File: tb/tb_monitor_uart_arbiter.sv
// Purpose: self-checking bench for monitor_uart_arbiter (table vectors, random traffic, RX corner cases).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: monitor busy/received behaviour modelled in-bench.
module tb_monitor_uart_arbiter;
  logic MCLK_IN = 1'b0;
  logic RUN_IN;
  always #5 MCLK_IN = ~MCLK_IN;

  monitor_uart_arbiter_if #(.RX_DEPTH(4)) bus();
  monitor_uart_arbiter #(.RX_DEPTH(4), .TRIG_CYCLES(2), .BUSY_TIMEOUT(15)) dut (
    .MCLK_IN(MCLK_IN), .RUN_IN(RUN_IN), .bus(bus));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor send side: records each byte on the trigger rise, busy rises 2 cycles later for 20 cycles.
  logic       busy_en = 1'b1;
  logic       trig_prev = 1'b0;
  int         bt = -1;
  int         busy_falls = 0;
  logic [7:0] sent_q[$];
  initial begin
    bus.UART_SEND_BUSY_IN = 1'b0;
    forever begin
      @(negedge MCLK_IN);
      if (bus.UART_SEND_TRIGGER === 1'b1 && !trig_prev) begin
        sent_q.push_back(bus.UART_SEND_BYTE);
        bt = busy_en ? 0 : -1;
      end else if (bt >= 0) begin
        bt++;
        if (bt == 2) bus.UART_SEND_BUSY_IN = 1'b1;
        if (bt == 22) begin
          bus.UART_SEND_BUSY_IN = 1'b0;
          busy_falls++;
          bt = -1;
        end
      end
      trig_prev = (bus.UART_SEND_TRIGGER === 1'b1);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation time bound expired");
    $fatal(1);
  end

  // One full send transfer from idle, checking grant, byte, strobe shape and return to idle.
  task automatic do_tx(input string tag, input logic cv, input logic [7:0] cb, input logic dv,
                       input logic [7:0] db, input logic exp_cpu, input logic [7:0] exp_b,
                       input logic use_busy);
    int n;
    int fb;
    busy_en = use_busy;
    fb = busy_falls;
    bus.CPU_TX_VALID_IN = cv; bus.CPU_TX_BYTE_IN = cb;
    bus.DBG_TX_VALID_IN = dv; bus.DBG_TX_BYTE_IN = db;
    n = 0;
    while (!(bus.CPU_TX_READY || bus.DBG_TX_READY) && n < 50) begin
      @(negedge MCLK_IN); n++;
    end
    if (n >= 50) begin
      expired({tag, "_grant"});
      bus.CPU_TX_VALID_IN = 1'b0; bus.DBG_TX_VALID_IN = 1'b0;
      return;
    end
    check({tag, "_who"}, {bus.CPU_TX_READY, bus.DBG_TX_READY}, exp_cpu ? 2'b10 : 2'b01);
    check({tag, "_byte"}, bus.UART_SEND_BYTE, exp_b);
    check({tag, "_trig_setup"}, bus.UART_SEND_TRIGGER, 1'b0);
    bus.CPU_TX_VALID_IN = 1'b0; bus.DBG_TX_VALID_IN = 1'b0;
    @(negedge MCLK_IN);
    check({tag, "_rdy_pulse"}, {bus.CPU_TX_READY, bus.DBG_TX_READY}, 2'b00);
    check({tag, "_trig_rise"}, bus.UART_SEND_TRIGGER, 1'b1);
    n = 0;
    while (bus.UART_SEND_TRIGGER && n < 10) begin
      @(negedge MCLK_IN); n++;
    end
    check({tag, "_trig_width"}, n, 2);
    n = 0;
    while (!bus.TX_IDLE && n < 100) begin
      @(negedge MCLK_IN); n++;
    end
    if (n >= 100) expired({tag, "_idle"});
    else if (use_busy) check({tag, "_idle_after_busy"}, busy_falls, fb + 1);
    else check({tag, "_timeout_len"}, n, 15);
    if (sent_q.size() == 0) expired({tag, "_monitor_byte"});
    else check({tag, "_monitor_byte"}, sent_q.pop_front(), exp_b);
    @(negedge MCLK_IN);
  endtask

  // Monitor receive side: present a byte until captured, then retract the flag.
  task automatic deliver(input string tag, input logic [7:0] b, input int exp_cnt);
    int n;
    bus.UART_RECEIVE_BYTE_IN = b;
    bus.UART_RECEIVED_IN = 1'b1;
    n = 0;
    while (!bus.UART_RECEIVE_CAPTURE && n < 20) begin
      @(negedge MCLK_IN); n++;
    end
    if (n >= 20) begin
      expired({tag, "_capture"});
    end else begin
      check({tag, "_count"}, bus.RX_COUNT, exp_cnt);
      n = 0;
      while (bus.UART_RECEIVE_CAPTURE && n < 10) begin
        @(negedge MCLK_IN); n++;
      end
      check({tag, "_capt_width"}, n, 2);
    end
    bus.UART_RECEIVED_IN = 1'b0;
    repeat (5) @(negedge MCLK_IN);
  endtask

  task automatic do_pop(input string tag, input logic [7:0] exp_b);
    check({tag, "_valid"}, bus.RX_VALID, 1'b1);
    check({tag, "_head"}, bus.RX_BYTE, exp_b);
    bus.RX_POP_IN = 1'b1;
    @(negedge MCLK_IN);
    bus.RX_POP_IN = 1'b0;
  endtask

  // Reference arbitration rule: a lone requester wins; a tie goes to whoever was not granted last.
  function automatic logic ref_cpu_wins(input logic cv, input logic dv, input logic last_dbg);
    if (cv && !dv) return 1'b1;
    if (dv && !cv) return 1'b0;
    return last_dbg;
  endfunction

  typedef struct {
    logic       cv;
    logic [7:0] cb;
    logic       dv;
    logic [7:0] db;
    logic       exp_cpu;
    logic [7:0] exp_b;
    logic       busy;
  } vec_t;

  vec_t       tbl[9];
  logic       m_last_dbg;
  logic [7:0] rq[$];

  initial begin
    logic cv, dv, ec, flag;
    logic [7:0] cb, db, rb;

    tbl[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 8'h33, 1'b0, 8'h33, 1'b1};
    tbl[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h11, 1'b1};
    tbl[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h22, 1'b1};
    tbl[4] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h11, 1'b1};
    tbl[5] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h22, 1'b1};
    tbl[6] = '{1'b1, 8'h44, 1'b1, 8'h55, 1'b1, 8'h44, 1'b0};
    tbl[7] = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 8'h66, 1'b1};
    tbl[8] = '{1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 8'h88, 1'b1};

    RUN_IN = 1'b0;
    bus.CPU_TX_VALID_IN = 1'b1; bus.CPU_TX_BYTE_IN = 8'h41;
    bus.DBG_TX_VALID_IN = 1'b0; bus.DBG_TX_BYTE_IN = 8'h00;
    bus.UART_RECEIVED_IN = 1'b0; bus.UART_RECEIVE_BYTE_IN = 8'h00;
    bus.RX_POP_IN = 1'b0;
`ifdef MONITOR_UART_LOOPBACK_EN
    bus.LOOPBACK_IN = 1'b0;
`endif

    // Reset held 3 cycles with a pending CPU request.
    for (int i = 0; i < 3; i++) begin
      @(negedge MCLK_IN);
      check($sformatf("rst%0d_ready", i), {bus.CPU_TX_READY, bus.DBG_TX_READY}, 2'b00);
      check($sformatf("rst%0d_strobes", i), {bus.UART_SEND_TRIGGER, bus.UART_RECEIVE_CAPTURE}, 2'b00);
      check($sformatf("rst%0d_tx_idle", i), bus.TX_IDLE, 1'b1);
      check($sformatf("rst%0d_rx_count", i), bus.RX_COUNT, 0);
    end
    check("rst_rx_valid", bus.RX_VALID, 1'b0);
    RUN_IN = 1'b1;

    for (int i = 0; i < 9; i++)
      do_tx($sformatf("tbl%0d", i), tbl[i].cv, tbl[i].cb, tbl[i].dv, tbl[i].db,
            tbl[i].exp_cpu, tbl[i].exp_b, tbl[i].busy);

    // Random transfers against the arbitration rule; table ended with a DBG grant.
    m_last_dbg = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!cv && !dv) cv = 1'b1;
      cb = 8'($urandom);
      db = 8'($urandom);
      ec = ref_cpu_wins(cv, dv, m_last_dbg);
      do_tx($sformatf("rnd%0d", i), cv, cb, dv, db, ec, ec ? cb : db, ($urandom_range(0, 3) != 0));
      m_last_dbg = ~ec;
    end

    // RX: fill the FIFO, the 5th byte is held until a pop frees space.
    for (int i = 1; i <= 4; i++) deliver($sformatf("rxfill%0d", i), 8'(i), i);
    bus.UART_RECEIVE_BYTE_IN = 8'h05;
    bus.UART_RECEIVED_IN = 1'b1;
    flag = 1'b0;
    repeat (10) begin
      @(negedge MCLK_IN);
      if (bus.UART_RECEIVE_CAPTURE) flag = 1'b1;
    end
    check("rxfull_no_capture", flag, 1'b0);
    check("rxfull_count", bus.RX_COUNT, 4);
    do_pop("rxfull_pop1", 8'h01);
    deliver("rx5", 8'h05, 4);
    for (int i = 2; i <= 5; i++) do_pop($sformatf("rxdrain%0d", i), 8'(i));
    check("rx_empty_valid", bus.RX_VALID, 1'b0);
    bus.RX_POP_IN = 1'b1;
    @(negedge MCLK_IN);
    bus.RX_POP_IN = 1'b0;
    check("rx_pop_empty_count", bus.RX_COUNT, 0);

    // Random RX push/pop against a queue.
    for (int i = 0; i < 25; i++) begin
      if ((rq.size() < 4) && ($urandom_range(0, 1) == 1 || rq.size() == 0)) begin
        rb = 8'($urandom);
        deliver($sformatf("rxr%0d", i), rb, rq.size() + 1);
        rq.push_back(rb);
      end else begin
        do_pop($sformatf("rxr%0d", i), rq.pop_front());
      end
      check($sformatf("rxr%0d_occ", i), bus.RX_COUNT, rq.size());
    end
    while (rq.size() > 0) do_pop("rxr_drain", rq.pop_front());

`ifdef MONITOR_UART_LOOPBACK_EN
    bus.LOOPBACK_IN = 1'b1;
    bus.DBG_TX_VALID_IN = 1'b1; bus.DBG_TX_BYTE_IN = 8'h5A;
    begin
      int n;
      n = 0;
      while (!bus.DBG_TX_READY && n < 20) begin
        @(negedge MCLK_IN); n++;
      end
      if (n >= 20) expired("lb_grant");
    end
    bus.DBG_TX_VALID_IN = 1'b0;
    check("lb_trig", bus.UART_SEND_TRIGGER, 1'b0);
    check("lb_rx_valid", bus.RX_VALID, 1'b1);
    check("lb_rx_byte", bus.RX_BYTE, 8'h5A);
    repeat (3) @(negedge MCLK_IN);
    check("lb_trig_after", bus.UART_SEND_TRIGGER, 1'b0);
    check("lb_tx_idle", bus.TX_IDLE, 1'b1);
    do_pop("lb_pop", 8'h5A);
    bus.LOOPBACK_IN = 1'b0;
    m_last_dbg = 1'b1;
`endif

    // Reset during a trigger pulse abandons the transfer and restores CPU tie priority.
    busy_en = 1'b1;
    bus.CPU_TX_VALID_IN = 1'b1; bus.CPU_TX_BYTE_IN = 8'h99;
    begin
      int n;
      n = 0;
      while (!bus.UART_SEND_TRIGGER && n < 50) begin
        @(negedge MCLK_IN); n++;
      end
      if (n >= 50) expired("midrst_trigger");
    end
    bus.CPU_TX_VALID_IN = 1'b0;
    RUN_IN = 1'b0;
    @(negedge MCLK_IN);
    check("midrst_trig_drop", bus.UART_SEND_TRIGGER, 1'b0);
    check("midrst_tx_idle", bus.TX_IDLE, 1'b1);
    RUN_IN = 1'b1;
    repeat (30) @(negedge MCLK_IN);
    sent_q.delete();
    do_tx("post_rst_tie", 1'b1, 8'hC3, 1'b1, 8'h3C, 1'b1, 8'hC3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
